// File: rtl/gate_tt_sequencer_if.sv
// Handshake and data bundle between the gate truth-table sequencer and the
// gate block under test / status consumer.
interface gate_tt_sequencer_if;
  logic       start;
  logic [1:0] ab_out;
  logic [5:0] y_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [1:0] fail_vec;
  logic [5:0] fail_mask;
  logic [2:0] err_count;

  modport master (
    input  start, y_in,
    output ab_out, busy, done, pass, fail_vec, fail_mask, err_count
  );

  modport slave (
    output start, y_in,
    input  ab_out, busy, done, pass, fail_vec, fail_mask, err_count
  );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Sweeps a,b through 00..11, waits SETTLE_CYCLES, then compares the six gate
// outputs against golden values and records pass/first-failure/error count.
module gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gate_tt_sequencer_if.master    bus
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ab_q, ab_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [1:0]    fail_vec_q, fail_vec_d;
  logic [5:0]    fail_mask_q, fail_mask_d;
  logic [2:0]    err_count_q, err_count_d;

  logic [5:0]    golden;
  logic [5:0]    diff;
  logic          a, b;

  // Golden order: {and, or, not(a), nand, xor, xnor}
  always_comb begin
    a      = ab_q[1];
    b      = ab_q[0];
    golden = {a & b, a | b, ~a, ~(a & b), a ^ b, ~(a ^ b)};
    diff   = bus.y_in ^ golden;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SETTLE;
      SETTLE:  if (cnt_q == CNT_LAST) state_d = CHECK;
      CHECK:   state_d = (ab_q == 2'b11) ? DONE : SETTLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    ab_d        = ab_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_vec_d  = fail_vec_q;
    fail_mask_d = fail_mask_q;
    err_count_d = err_count_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ab_d        = '0;
          err_count_d = '0;
          fail_vec_d  = '0;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = '0;
        end
      end
      SETTLE: cnt_d = cnt_q + 1'b1;
      CHECK: begin
        if (|diff) begin
          err_count_d = err_count_q + 1'b1;
          if (err_count_q == '0) begin
            fail_vec_d  = ab_q;
            fail_mask_d = diff;
          end
        end
        if (ab_q == 2'b11) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          ab_d  = ab_q + 1'b1;
          cnt_d = '0;
        end
      end
      DONE:    pass_d = (err_count_q == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ab_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_vec_q  <= '0;
      fail_mask_q <= '0;
      err_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ab_q        <= ab_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_vec_q  <= fail_vec_d;
      fail_mask_q <= fail_mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.ab_out    = ab_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_mask = fail_mask_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: two instances (SETTLE_CYCLES 2 and 1) driven by
// an emulated gate block, checked each cycle against a timeline model.
module tb_gate_tt_sequencer;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            glitch_en = 1'b0;
  logic [3:0][5:0] fault_tab = '0;
  int              n_cmp = 0;
  int              n_bad = 0;

  always #5 clk = ~clk;

  // Gate outputs derived from the count of ones on the inputs.
  function automatic logic [5:0] gold(input logic [1:0] v);
    int a, s;
    logic [5:0] r;
    a = int'(v[1]);
    s = a + int'(v[0]);
    r[5] = (s == 2);
    r[4] = (s > 0);
    r[3] = (a == 0);
    r[2] = (s < 2);
    r[1] = (s == 1);
    r[0] = (s != 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int unsigned S        = (g == 0) ? 2 : 1;
    localparam int unsigned VLEN     = S + 1;
    localparam int unsigned BUSY_LIT = (g == 0) ? 12 : 8;

    gate_tt_sequencer_if bus ();

    gate_tt_sequencer #(.SETTLE_CYCLES(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    assign bus.start = start;

    logic            m_active = 1'b0;
    logic            m_done = 1'b0;
    int unsigned     m_t = 0;
    int unsigned     run = 0;
    logic [3:0][5:0] snap = '0;
    logic [1:0]      e_ab = '0;
    logic            e_busy = 1'b0;
    logic            e_done = 1'b0;
    logic            e_pass = 1'b0;
    logic [1:0]      e_fv = '0;
    logic [5:0]      e_fm = '0;
    logic [2:0]      e_ec = '0;

    // Timeline model: sweep cycle m_t belongs to vector m_t/VLEN and is the
    // sampling cycle when m_t%VLEN == S.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_active <= 1'b0; m_done <= 1'b0; m_t <= 0;
        e_ab <= '0; e_busy <= 1'b0; e_done <= 1'b0; e_pass <= 1'b0;
        e_fv <= '0; e_fm <= '0; e_ec <= '0;
      end else if (m_done) begin
        m_done <= 1'b0;
        e_done <= 1'b0;
        e_pass <= (e_ec == 3'd0);
      end else if (m_active) begin
        if ((m_t % VLEN) == S && snap[m_t / VLEN] != 6'd0) begin
          e_ec <= e_ec + 3'd1;
          if (e_ec == 3'd0) begin
            e_fv <= 2'(m_t / VLEN);
            e_fm <= snap[m_t / VLEN];
          end
        end
        if (m_t + 1 == 4 * VLEN) begin
          m_active <= 1'b0; m_done <= 1'b1; e_busy <= 1'b0; e_done <= 1'b1;
        end else begin
          e_ab <= 2'((m_t + 1) / VLEN);
        end
        m_t <= m_t + 1;
      end else if (start) begin
        m_active <= 1'b1; m_t <= 0; snap <= fault_tab;
        e_ab <= '0; e_busy <= 1'b1; e_ec <= '0; e_fv <= '0; e_fm <= '0; e_pass <= 1'b0;
      end
    end

    always @(negedge clk) begin
      bus.y_in <= gold(bus.ab_out) ^ snap[bus.ab_out] ^
                  ((glitch_en && !(m_active && (m_t % VLEN) == S)) ? 6'($urandom) : 6'd0);
      check($sformatf("g%0d ab_out", g),    32'(bus.ab_out),    32'(e_ab));
      check($sformatf("g%0d busy", g),      32'(bus.busy),      32'(e_busy));
      check($sformatf("g%0d done", g),      32'(bus.done),      32'(e_done));
      check($sformatf("g%0d pass", g),      32'(bus.pass),      32'(e_pass));
      check($sformatf("g%0d fail_vec", g),  32'(bus.fail_vec),  32'(e_fv));
      check($sformatf("g%0d fail_mask", g), 32'(bus.fail_mask), 32'(e_fm));
      check($sformatf("g%0d err_count", g), 32'(bus.err_count), 32'(e_ec));
      if (!rst_n) run <= 0;
      else if (bus.done === 1'b1) begin
        check($sformatf("g%0d busy_len", g), 32'(run), 32'(BUSY_LIT));
        run <= 0;
      end else if (bus.busy === 1'b1) run <= run + 1;
    end
  end

  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (g_i[0].bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done want done within 200 cycles at %0t", $time);
    end
  endtask

  task automatic lit_results(input string tag, input logic p, input logic [1:0] fv,
                             input logic [5:0] fm, input logic [2:0] ec);
    check({tag, " g0 pass"}, 32'(g_i[0].bus.pass), 32'(p));
    check({tag, " g0 fail_vec"}, 32'(g_i[0].bus.fail_vec), 32'(fv));
    check({tag, " g0 fail_mask"}, 32'(g_i[0].bus.fail_mask), 32'(fm));
    check({tag, " g0 err_count"}, 32'(g_i[0].bus.err_count), 32'(ec));
    check({tag, " g1 pass"}, 32'(g_i[1].bus.pass), 32'(p));
    check({tag, " g1 err_count"}, 32'(g_i[1].bus.err_count), 32'(ec));
    check({tag, " g0 ab_hold"}, 32'(g_i[0].bus.ab_out), 32'd3);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Clean sweep
    pulse_start();
    wait_done();
    @(negedge clk);
    lit_results("t1", 1'b1, 2'd0, 6'd0, 3'd0);

    // Stuck-at-zero gate block
    for (int v = 0; v < 4; v++) fault_tab[v] = gold(2'(v));
    pulse_start();
    wait_done();
    @(negedge clk);
    lit_results("t2", 1'b0, 2'd0, 6'b001101, 3'd4);

    // Only xor wrong at ab=10, with an ignored start pulse mid-sweep
    fault_tab = '0;
    fault_tab[2] = 6'b000010;
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done();
    @(negedge clk);
    lit_results("t3", 1'b0, 2'd2, 6'b000010, 3'd1);

    // Reset during CHECK of vector 01 (instance 0)
    fault_tab = '0;
    @(negedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4 busy_async", 32'(g_i[0].bus.busy), 32'd0);
    check("t4 ab_async", 32'(g_i[0].bus.ab_out), 32'd0);
    check("t4 err_async", 32'(g_i[0].bus.err_count), 32'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    pulse_start();
    wait_done();
    @(negedge clk);
    lit_results("t4", 1'b1, 2'd0, 6'd0, 3'd0);

    // Start held high: back-to-back sweeps
    @(negedge clk); #1 start = 1'b1;
    repeat (40) @(negedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);

    // Glitches on y_in only outside the sampling cycle
    glitch_en = 1'b1;
    pulse_start();
    wait_done();
    @(negedge clk);
    lit_results("t6", 1'b1, 2'd0, 6'd0, 3'd0);
    glitch_en = 1'b0;

    // Randomized traffic
    repeat (800) begin
      @(negedge clk); #1;
      start = ($urandom % 6) == 0;
      glitch_en = $urandom % 2;
      if (($urandom % 10) == 0)
        fault_tab[$urandom % 4] = (($urandom % 3) == 0) ? 6'($urandom) : 6'd0;
    end
    start = 1'b0;
    glitch_en = 1'b0;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
